limber_gnrl_ramtdp_be: RTL and testbench

//  Parametrised true dual-port RAM, successor to the generic TDP RAM; used for

---
 rtl/limber_gnrl_ramtdp_be_pkg.sv | 14 +
 rtl/limber_gnrl_dlyline.sv | 37 +++
 rtl/limber_gnrl_ramtdp_be.sv | 179 +++++++++++++++++
 tb/tb_limber_gnrl_ramtdp_be.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/limber_gnrl_ramtdp_be_pkg.sv
// Shared constants and clear-engine states for the
// byte-enable true dual-port RAM.
package limber_gnrl_ramtdp_be_pkg;

  localparam int WMODE_READ_FIRST  = 0;
  localparam int WMODE_WRITE_FIRST = 1;
  localparam int WMODE_NO_CHANGE   = 2;

  typedef enum logic {
    CLR = 1'b0,
    RDY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/limber_gnrl_dlyline.sv
// Fixed-latency pipe carrying read data plus a valid bit.
// Synchronous reset clears every stage to zero.
module limber_gnrl_dlyline #(
  parameter int W   = 32,
  parameter int DLY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic         vld_q [DLY];
  logic [W-1:0] dat_q [DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      dat_q[0] <= in_data;
      for (int i = 1; i < DLY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DLY-1];
  assign out_data = dat_q[DLY-1];

endmodule

// File: rtl/limber_gnrl_ramtdp_be.sv
// True dual-port RAM with lane write enables, same-port
// write modes, post-reset clear and write collision flag.
module limber_gnrl_ramtdp_be
  import limber_gnrl_ramtdp_be_pkg::*;
#(
  parameter int DP           = 16,
  parameter int AW           = 4,
  parameter int DW           = 32,
  parameter int BW           = 8,
  parameter int DLY          = 1,
  parameter int WMODE        = 0,
  parameter int INIT_CLR     = 1,
  parameter int FORCE_X2ZERO = 0,
  localparam int NB          = DW / BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_a,
  input  logic [NB-1:0] we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] din_a,
  output logic [DW-1:0] dout_a,
  input  logic          cs_b,
  input  logic [NB-1:0] we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] din_b,
  output logic [DW-1:0] dout_b,
  output logic          init_done,
  output logic          coll_err
);

  localparam logic [AW:0]   DPW  = (AW+1)'(DP);
  localparam logic [AW-1:0] LAST = AW'(DP - 1);

  logic [DW-1:0] mem [DP];

  clr_state_e    state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;

  logic          cs   [2];
  logic [NB-1:0] we   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] din  [2];

  logic          act  [2];
  logic          inr  [2];
  logic          wr   [2];
  logic          rvld [2];
  logic [DW-1:0] old  [2];
  logic [DW-1:0] mrg  [2];
  logic [DW-1:0] rdat [2];
  logic          ovld [2];
  logic [DW-1:0] odat [2];
  logic [DW-1:0] dq   [2];

  assign cs[0]   = cs_a;
  assign cs[1]   = cs_b;
  assign we[0]   = we_a;
  assign we[1]   = we_b;
  assign addr[0] = addr_a;
  assign addr[1] = addr_b;
  assign din[0]  = din_a;
  assign din[1]  = din_b;

  assign init_done = (state_q == RDY);

  // Reads see the array before this edge's writes land.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      act[p]  = cs[p] & init_done & ~rst;
      inr[p]  = {1'b0, addr[p]} < DPW;
      old[p]  = inr[p] ? mem[addr[p]] : '0;
      wr[p]   = act[p] & (|we[p]) & inr[p];
      mrg[p]  = '0;
      for (int k = 0; k < NB; k++) begin
        mrg[p][k*BW +: BW] = we[p][k] ? din[p][k*BW +: BW]
                                      : old[p][k*BW +: BW];
      end
      rvld[p] = act[p] &
                ((we[p] == '0) | (WMODE != WMODE_NO_CHANGE));
      rdat[p] = old[p];
      if ((we[p] != '0) && (WMODE == WMODE_WRITE_FIRST) && inr[p])
        rdat[p] = mrg[p];
    end
  end

  // Port B is applied first so port A wins shared lanes.
  always_ff @(posedge clk) begin
    if (!rst && state_q == CLR) begin
      mem[clr_q] <= '0;
    end else begin
      for (int p = 1; p >= 0; p--) begin
        if (wr[p]) begin
          for (int k = 0; k < NB; k++) begin
            if (we[p][k])
              mem[addr[p]][k*BW +: BW] <= din[p][k*BW +: BW];
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == LAST) state_d = RDY;
      end
      RDY: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_CLR != 0) ? CLR : RDY;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) coll_err <= 1'b0;
    else coll_err <= wr[0] & wr[1] & (addr[0] == addr[1]);
  end

  limber_gnrl_dlyline #(
    .W   (DW),
    .DLY (DLY)
  ) u_dly_a (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rvld[0]),
    .in_data  (rdat[0]),
    .out_vld  (ovld[0]),
    .out_data (odat[0])
  );

  limber_gnrl_dlyline #(
    .W   (DW),
    .DLY (DLY)
  ) u_dly_b (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rvld[1]),
    .in_data  (rdat[1]),
    .out_vld  (ovld[1]),
    .out_data (odat[1])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dq[0] <= '0;
      dq[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ovld[p]) dq[p] <= odat[p];
      end
    end
  end

  generate
    if (FORCE_X2ZERO != 0) begin : g_x2z
      always_comb begin
        for (int i = 0; i < DW; i++) begin
          dout_a[i] = (dq[0][i] === 1'b1);
          dout_b[i] = (dq[1][i] === 1'b1);
        end
      end
    end else begin : g_raw
      assign dout_a = dq[0];
      assign dout_b = dq[1];
    end
  endgenerate

endmodule

// File: tb/tb_limber_gnrl_ramtdp_be.sv
// Bench for limber_gnrl_ramtdp_be: three configurations
// share one stimulus stream and one behavioural model.
module tb_limber_gnrl_ramtdp_be;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        tcs [2];
  logic [3:0]  twe [2];
  logic [3:0]  tad [2];
  logic [31:0] tdn [2];

  logic [31:0] da [3];
  logic [31:0] db [3];
  logic        cer [3];
  logic        idn [3];

  int checks = 0;
  int errors = 0;

  int dp_m  [3] = '{16, 12, 16};
  int dly_m [3] = '{1, 3, 2};
  int wm_m  [3] = '{0, 1, 2};

  logic [31:0] mem_m [3][16];
  bit          pv    [3][2][5];
  logic [31:0] pd    [3][2][5];
  logic [31:0] edo   [3][2];
  logic        ec    [3];
  int          clr_m [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  limber_gnrl_ramtdp_be #(
    .DP(16), .AW(4), .DLY(1), .WMODE(0)
  ) d0 (
    .clk(clk), .rst(rst),
    .cs_a(tcs[0]), .we_a(twe[0]), .addr_a(tad[0]),
    .din_a(tdn[0]), .dout_a(da[0]),
    .cs_b(tcs[1]), .we_b(twe[1]), .addr_b(tad[1]),
    .din_b(tdn[1]), .dout_b(db[0]),
    .init_done(idn[0]), .coll_err(cer[0])
  );

  limber_gnrl_ramtdp_be #(
    .DP(12), .AW(4), .DLY(3), .WMODE(1)
  ) d1 (
    .clk(clk), .rst(rst),
    .cs_a(tcs[0]), .we_a(twe[0]), .addr_a(tad[0]),
    .din_a(tdn[0]), .dout_a(da[1]),
    .cs_b(tcs[1]), .we_b(twe[1]), .addr_b(tad[1]),
    .din_b(tdn[1]), .dout_b(db[1]),
    .init_done(idn[1]), .coll_err(cer[1])
  );

  limber_gnrl_ramtdp_be #(
    .DP(16), .AW(4), .DLY(2), .WMODE(2)
  ) d2 (
    .clk(clk), .rst(rst),
    .cs_a(tcs[0]), .we_a(twe[0]), .addr_a(tad[0]),
    .din_a(tdn[0]), .dout_a(da[2]),
    .cs_b(tcs[1]), .we_b(twe[1]), .addr_b(tad[1]),
    .din_b(tdn[1]), .dout_b(db[2]),
    .init_done(idn[2]), .coll_err(cer[2])
  );

  // Reference: word array, scheduled read results, clear countdown.
  function automatic void model_edge();
    logic [31:0] old, nw;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          for (int s = 0; s < 5; s++) pv[i][p][s] = 0;
          edo[i][p] = 0;
        end
        ec[i] = 0;
        clr_m[i] = dp_m[i];
        continue;
      end
      ec[i] = 0;
      for (int p = 0; p < 2; p++) begin
        if (pv[i][p][1]) edo[i][p] = pd[i][p][1];
        for (int s = 1; s < 4; s++) begin
          pv[i][p][s] = pv[i][p][s+1];
          pd[i][p][s] = pd[i][p][s+1];
        end
        pv[i][p][4] = 0;
      end
      if (clr_m[i] > 0) begin
        mem_m[i][dp_m[i] - clr_m[i]] = 0;
        clr_m[i]--;
        continue;
      end
      for (int p = 0; p < 2; p++) begin
        if (!tcs[p]) continue;
        ok  = int'(tad[p]) < dp_m[i];
        old = ok ? mem_m[i][tad[p]] : 32'h0;
        nw  = old;
        for (int k = 0; k < 4; k++)
          if (twe[p][k]) nw[k*8 +: 8] = tdn[p][k*8 +: 8];
        if (!ok) nw = 0;
        if (twe[p] == 0 || wm_m[i] == 0) begin
          pv[i][p][dly_m[i]] = 1;
          pd[i][p][dly_m[i]] = old;
        end else if (wm_m[i] == 1) begin
          pv[i][p][dly_m[i]] = 1;
          pd[i][p][dly_m[i]] = nw;
        end
      end
      for (int p = 1; p >= 0; p--) begin
        if (tcs[p] && int'(tad[p]) < dp_m[i])
          for (int k = 0; k < 4; k++)
            if (twe[p][k])
              mem_m[i][tad[p]][k*8 +: 8] = tdn[p][k*8 +: 8];
      end
      ec[i] = tcs[0] && tcs[1] && twe[0] != 0 && twe[1] != 0 &&
              tad[0] == tad[1] && int'(tad[0]) < dp_m[i];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drv(input int p, input logic c, input logic [3:0] w,
                     input logic [3:0] a, input logic [31:0] d);
    tcs[p] = c;
    twe[p] = w;
    tad[p] = a;
    tdn[p] = d;
  endtask

  task automatic idle(input int n);
    drv(0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic rand_drive();
    for (int p = 0; p < 2; p++) begin
      tcs[p] = 1'($urandom_range(0, 1));
      twe[p] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      tad[p] = 4'($urandom);
      tdn[p] = $urandom;
    end
    if ($urandom_range(0, 5) == 0) tad[1] = tad[0];
  endtask

  task automatic test_reset();
    idle(0);
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({da[i], db[i], cer[i], idn[i]} !== 66'h0) begin
        errors++;
        $display("FAIL reset inst%0d got %h/%h/%b/%b exp 0/0/0/0",
                 i, da[i], db[i], cer[i], idn[i]);
      end
    end
  endtask

  task automatic test_clear();
    int t [3];
    t = '{0, 0, 0};
    for (int n = 1; n <= 20; n++) begin
      tick();
      for (int i = 0; i < 3; i++)
        if (idn[i] && t[i] == 0) t[i] = n;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (t[i] != dp_m[i]) begin
        errors++;
        $display("FAIL clear_time inst%0d got %0d exp %0d", i, t[i], dp_m[i]);
      end
    end
    for (int a = 0; a < 16; a += 2) begin
      drv(0, 1, 4'hf, 4'(a), $urandom | 32'h1);
      drv(1, 1, 4'hf, 4'(a + 1), $urandom | 32'h1);
      tick();
    end
    idle(0);
    rst = 1;
    tick();
    rst = 0;
    idle(16);
    for (int a = 0; a < 16; a++) begin
      drv(0, 1, 0, 4'(a), 0);
      tick();
      idle(4);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (da[i] !== 32'h0) begin
          errors++;
          $display("FAIL clear_word inst%0d addr %0d got %h exp 0",
                   i, a, da[i]);
        end
      end
    end
  endtask

  task automatic test_mid_clear();
    int t0;
    rst = 1;
    tick();
    rst = 0;
    for (int n = 0; n < 7; n++) begin
      rand_drive();
      tick();
    end
    idle(0);
    rst = 1;
    tick();
    rst = 0;
    t0 = 0;
    for (int n = 1; n <= 20; n++) begin
      if (t0 == 0) rand_drive();
      else idle(0);
      tick();
      if (idn[0] && t0 == 0) t0 = n;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({da[i], db[i], cer[i], idn[i]} !==
            {edo[i][0], edo[i][1], ec[i], clr_m[i] == 0}) begin
          errors++;
          $display("FAIL midclr inst%0d got %h/%h/%b/%b exp %h/%h/%b/%b",
                   i, da[i], db[i], cer[i], idn[i], edo[i][0],
                   edo[i][1], ec[i], clr_m[i] == 0);
        end
      end
    end
    checks++;
    if (t0 != 16) begin
      errors++;
      $display("FAIL midclr_time got %0d exp 16", t0);
    end
    idle(2);
  endtask

  task automatic test_wmode();
    logic [31:0] exp [3];
    exp = '{32'h11223344, 32'h11BB33DD, 32'h55667788};
    drv(0, 1, 4'hf, 4'd3, 32'h11223344);
    tick();
    drv(0, 1, 4'hf, 4'd4, 32'h55667788);
    tick();
    drv(0, 1, 4'h0, 4'd4, 0);
    tick();
    idle(4);
    drv(0, 1, 4'b0101, 4'd3, 32'hAABBCCDD);
    tick();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (da[i] !== exp[i]) begin
        errors++;
        $display("FAIL wmode inst%0d got %h exp %h", i, da[i], exp[i]);
      end
    end
    drv(0, 1, 4'h0, 4'd3, 0);
    tick();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (da[i] !== 32'h11BB33DD) begin
        errors++;
        $display("FAIL wmode_mem inst%0d got %h exp 11bb33dd", i, da[i]);
      end
    end
  endtask

  task automatic test_collision();
    drv(0, 1, 4'b1100, 4'd5, 32'hFFFF0000);
    drv(1, 1, 4'b1111, 4'd5, 32'h0000FFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cer[i] !== 1'b1) begin
        errors++;
        $display("FAIL coll_hi inst%0d got %b exp 1", i, cer[i]);
      end
    end
    idle(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cer[i] !== 1'b0) begin
        errors++;
        $display("FAIL coll_lo inst%0d got %b exp 0", i, cer[i]);
      end
    end
    drv(0, 1, 0, 4'd5, 0);
    drv(1, 1, 0, 4'd5, 0);
    tick();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({da[i], db[i]} !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
        errors++;
        $display("FAIL coll_mem inst%0d got %h/%h exp ffffffff",
                 i, da[i], db[i]);
      end
    end
  endtask

  task automatic test_latency();
    for (int a = 0; a < 3; a++) begin
      drv(0, 1, 4'hf, 4'(a), 32'h0BAD0000 | a);
      tick();
    end
    idle(4);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drv(0, 1, 0, 4'(k), 0);
      else idle(0);
      tick();
      checks++;
      if (k >= 3 && da[1] !== (32'h0BAD0000 | (k - 3))) begin
        errors++;
        $display("FAIL lat3 edge+%0d got %h exp %h",
                 k, da[1], 32'h0BAD0000 | (k - 3));
      end else if (k < 3 && da[1] !== edo[1][0]) begin
        errors++;
        $display("FAIL lat3_hold edge+%0d got %h exp %h",
                 k, da[1], edo[1][0]);
      end
    end
    drv(0, 1, 4'hf, 4'd1, 32'hDEADBEEF);
    drv(1, 1, 4'h0, 4'd1, 0);
    tick();
    idle(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (db[i] !== 32'h0BAD0001) begin
        errors++;
        $display("FAIL xport inst%0d got %h exp 0bad0001", i, db[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    drv(0, 1, 4'hf, 4'd13, 32'h13131313);
    tick();
    drv(0, 1, 0, 4'd13, 0);
    drv(1, 1, 0, 4'd1, 0);
    tick();
    idle(4);
    checks++;
    if ({da[1], db[1]} !== {32'h0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL oor got %h/%h exp 0/deadbeef", da[1], db[1]);
    end
    checks++;
    if (da[0] !== 32'h13131313) begin
      errors++;
      $display("FAIL oor_inrange got %h exp 13131313", da[0]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_drive();
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({da[i], db[i], cer[i], idn[i]} !==
            {edo[i][0], edo[i][1], ec[i], clr_m[i] == 0}) begin
          errors++;
          $display("FAIL rand inst%0d got %h/%h/%b/%b exp %h/%h/%b/%b",
                   i, da[i], db[i], cer[i], idn[i], edo[i][0],
                   edo[i][1], ec[i], clr_m[i] == 0);
        end
      end
    end
    idle(1);
  endtask

  initial begin
    idle(0);
    for (int i = 0; i < 3; i++)
      for (int a = 0; a < 16; a++) mem_m[i][a] = 0;
    test_reset();
    test_clear();
    test_mid_clear();
    test_wmode();
    test_collision();
    test_latency();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
